// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writebacks always win, MDU results
// queue in a small FIFO and drain into idle cycles, with starvation-driven bubble requests.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        drain_req,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  output logic        pend_rs,
  output logic        pend_rt
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]    r_reg_mem  [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [SW-1:0] r_starve;
  logic          r_drain;

  logic          w_empty;
  logic          w_full;
  logic          w_pipe_live;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [SW-1:0] w_starve_next;
  logic [DEPTH-1:0] w_match_rs;
  logic [DEPTH-1:0] w_match_rt;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_COUNT);
  assign w_pipe_live = RegWriteW && (WriteRegW != 5'd0);

  // Fullness is judged before any same-cycle pop, so a full FIFO never accepts.
  assign mdu_ready = !reset && !w_full;
  assign w_accept  = mdu_valid && mdu_ready;
  assign w_push    = w_accept && (mdu_reg != 5'd0);
  assign w_pop     = !reset && !w_pipe_live && !w_empty;

  always_comb begin
    rf_we = 1'b0;
    rf_wa = 5'd0;
    rf_wd = 32'd0;
    if (!reset) begin
      if (w_pipe_live) begin
        rf_we = 1'b1;
        rf_wa = WriteRegW;
        rf_wd = ResultW;
      end else if (!w_empty) begin
        rf_we = 1'b1;
        rf_wa = r_reg_mem[r_rd_ptr];
        rf_wd = r_data_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_reg_mem[r_wr_ptr]  <= mdu_reg;
      r_data_mem[r_wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_starve_next = r_starve;
    if (w_pop || w_empty) begin
      w_starve_next = '0;
    end else if (r_starve < STARVE_MAX) begin
      w_starve_next = r_starve + 1'b1;
    end
  end

  // drain_req mirrors the saturated counter one-for-one, so it falls right after a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
      r_drain  <= 1'b0;
    end else begin
      r_starve <= w_starve_next;
      r_drain  <= (w_starve_next == STARVE_MAX);
    end
  end

  assign drain_req = r_drain;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pend
      logic [AW-1:0] w_offset;
      logic          w_valid;
      // An entry is live when its distance from the head is below the count.
      assign w_offset       = AW'(gi) - r_rd_ptr;
      assign w_valid        = ({1'b0, w_offset} < r_count);
      assign w_match_rs[gi] = w_valid && (r_reg_mem[gi] == rsD);
      assign w_match_rt[gi] = w_valid && (r_reg_mem[gi] == rtD);
    end
  endgenerate

  assign pend_rs = (rsD != 5'd0) && (|w_match_rs);
  assign pend_rt = (rtD != 5'd0) && (|w_match_rt);

endmodule
